// File: rtl/bsg_two_fifo_pkg.sv
// bsg_two_fifo_pkg: shared payload/pointer types for the two-entry FIFO
package bsg_two_fifo_pkg;
  localparam int width_lp = 9;
  typedef logic [width_lp-1:0] payload_t;
  typedef logic [0:0] ptr_t;
endpackage

// File: rtl/bsg_mem_1r1w_sync_els_p2_width_p9.sv
// bsg_mem_1r1w_sync_els_p2_width_p9: 2x9 register array (clk_i; w_v_i/w_addr_i/w_data_i write; r_addr_i -> r_data_o async read; no reset)
module bsg_mem_1r1w_sync_els_p2_width_p9
  import bsg_two_fifo_pkg::*;
(
  input  logic     clk_i,
  input  logic     w_v_i,
  input  ptr_t     w_addr_i,
  input  payload_t w_data_i,
  input  ptr_t     r_addr_i,
  output payload_t r_data_o
);
  payload_t mem_r [2];
  always_ff @(posedge clk_i)
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  assign r_data_o = mem_r[r_addr_i];
endmodule

// File: rtl/bsg_two_fifo_width_p9.sv
// bsg_two_fifo_width_p9: two-entry FIFO (clk_i, reset_i; v_i/data_i/ready_o ready-valid in; v_o/data_o/yumi_i valid-yumi out)
module bsg_two_fifo_width_p9
  import bsg_two_fifo_pkg::*;
#(
  parameter int width_p = 9,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  if (els_p != 2) begin : g_bad_els
    $error("bsg_two_fifo_width_p9: els_p must be 2");
  end
  if (width_p != width_lp) begin : g_bad_width
    $error("bsg_two_fifo_width_p9: width_p must be 9");
  end
  ptr_t head_r, tail_r;
  logic empty_r, full_r, enq, deq;
  assign ready_o = ~full_r & ~reset_i;
  assign v_o     = ~empty_r;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  bsg_mem_1r1w_sync_els_p2_width_p9 mem (
    .clk_i    (clk_i),
    .w_v_i    (enq),
    .w_addr_i (tail_r),
    .w_data_i (data_i),
    .r_addr_i (head_r),
    .r_data_o (data_o)
  );
  always_ff @(posedge clk_i)
    if (reset_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (enq) tail_r <= ~tail_r;
      if (deq) head_r <= ~head_r;
      if (enq & ~deq) begin
        empty_r <= 1'b0;
        full_r  <= (head_r == ~tail_r);
      end else if (deq & ~enq) begin
        full_r  <= 1'b0;
        empty_r <= (~head_r == tail_r);
      end
    end
endmodule
